// File: rtl/hub75_column_driver_if.sv
// Transfer bus between the column formatter (master) and the HUB75 column driver (slave):
// two half-lines of pixels plus the row-pair address, qualified by data_valid/hub75_ready.
interface hub75_column_driver_if #(
  parameter int SCAN_RATE = 32,
  parameter int NUM_ROWS  = 64,
  parameter int RGB_RES   = 9
);
  logic                                       data_valid;
  logic [$clog2(SCAN_RATE)-1:0]               col_num;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      columns;
  logic                                       hub75_ready;

  modport master (output data_valid, col_num, columns, input hub75_ready);
  modport slave  (input data_valid, col_num, columns, output hub75_ready);
endinterface

// File: rtl/hub75_column_driver.sv
// Shifts one captured HUB75 line transfer into the panel as bit-planes, each lit for a
// binary-weighted output-enable window, then returns to ready for the next transfer.
module hub75_column_driver #(
  parameter int NUM_COLS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int NUM_ROWS  = 64,
  parameter int RGB_RES   = 9,
  parameter int CLK_DIV   = 1,
  parameter int OE_BASE   = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  hub75_column_driver_if.slave         bus,
  output logic [2:0]                   hub75_rgb0,
  output logic [2:0]                   hub75_rgb1,
  output logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
  output logic                         hub75_clk,
  output logic                         hub75_lat,
  output logic                         hub75_oe_n
);
  localparam int ADDR_W = $clog2(SCAN_RATE);
  localparam int PLANES = RGB_RES / 3;
  localparam int PIX_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int OE_MAX = OE_BASE << (PLANES - 1);
  localparam int OE_W   = (OE_MAX > 1) ? $clog2(OE_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

  state_t                                state;
  logic                                  ready;
  logic [PL_W-1:0]                       plane;
  logic [PIX_W-1:0]                      pix;
  logic [PIX_W-1:0]                      pix_inc;
  logic [PH_W-1:0]                       phase;
  logic [OE_W-1:0]                       oe_cnt;
  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] pix_buf;
  logic [ADDR_W-1:0]                     addr_buf;
  logic                                  accept;

  assign bus.hub75_ready = ready;
  assign accept          = (state == S_IDLE) && ready && bus.data_valid;
  assign pix_inc         = pix + 1'b1;

  // {R[p],G[p],B[p]} with the pixel packed as {R,G,B}, each channel PLANES bits wide.
  function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px, input logic [PL_W-1:0] p);
    return {px[2*PLANES + int'(p)], px[PLANES + int'(p)], px[int'(p)]};
  endfunction

  // NOTE: the line buffer is plain storage, so it has no reset; every entry is written on acceptance before use.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < NUM_COLS; i++)
          pix_buf[h][i] <= bus.columns[h][i];
      addr_buf <= bus.col_num;
    end
  end

  // NOTE: every pin is a register set together with the state, so the panel never sees combinational glitches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= S_IDLE;
      ready      <= 1'b0;
      plane      <= '0;
      pix        <= '0;
      phase      <= '0;
      oe_cnt     <= '0;
      hub75_rgb0 <= '0;
      hub75_rgb1 <= '0;
      hub75_addr <= '0;
      hub75_clk  <= 1'b0;
      hub75_lat  <= 1'b0;
      hub75_oe_n <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          hub75_clk  <= 1'b0;
          hub75_lat  <= 1'b0;
          hub75_oe_n <= 1'b1;
          if (accept) begin
            state      <= S_SHIFT;
            ready      <= 1'b0;
            plane      <= '0;
            pix        <= '0;
            phase      <= '0;
            hub75_rgb0 <= plane_bits(bus.columns[0][0], PL_W'(0));
            hub75_rgb1 <= plane_bits(bus.columns[1][0], PL_W'(0));
          end else begin
            ready      <= 1'b1;
            hub75_rgb0 <= '0;
            hub75_rgb1 <= '0;
          end
        end
        S_SHIFT: begin
          if (phase != PH_W'(CLK_DIV - 1)) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (!hub75_clk) begin
              hub75_clk <= 1'b1;
            end else begin
              hub75_clk <= 1'b0;
              if (pix == PIX_W'(NUM_COLS - 1)) begin
                // Address moves only here, while the panel is blanked and nothing is latching.
                state      <= S_BLANK;
                hub75_addr <= addr_buf;
              end else begin
                pix        <= pix_inc;
                hub75_rgb0 <= plane_bits(pix_buf[0][pix_inc], plane);
                hub75_rgb1 <= plane_bits(pix_buf[1][pix_inc], plane);
              end
            end
          end
        end
        S_BLANK: begin
          state     <= S_LATCH;
          hub75_lat <= 1'b1;
        end
        S_LATCH: begin
          state      <= S_DISPLAY;
          hub75_lat  <= 1'b0;
          hub75_oe_n <= 1'b0;
          oe_cnt     <= '0;
        end
        S_DISPLAY: begin
          if (int'(oe_cnt) == (OE_BASE << plane) - 1) begin
            hub75_oe_n <= 1'b1;
            pix        <= '0;
            phase      <= '0;
            if (plane == PL_W'(PLANES - 1)) begin
              state      <= S_IDLE;
              ready      <= 1'b1;
              hub75_rgb0 <= '0;
              hub75_rgb1 <= '0;
            end else begin
              state      <= S_SHIFT;
              plane      <= plane + 1'b1;
              hub75_rgb0 <= plane_bits(pix_buf[0][0], plane + 1'b1);
              hub75_rgb1 <= plane_bits(pix_buf[1][0], plane + 1'b1);
            end
          end else begin
            oe_cnt <= oe_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_column_driver.sv
// Scoreboard bench for hub75_column_driver: a CLK_DIV=1 instance with reset, plane, handshake and
// address-safety checks, plus a CLK_DIV=3 instance checking shift-clock phase timing.
module tb_hub75_column_driver;
  localparam int NC = 64, SR = 32, NR = 64, RR = 9, NR2 = 72;

  typedef logic [1:0][NR-1:0][RR-1:0]  cols_t;
  typedef logic [1:0][NR2-1:0][RR-1:0] cols2_t;
  typedef struct { int busy; bit b2b; } xfer_t;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  hub75_column_driver_if #(.SCAN_RATE(SR), .NUM_ROWS(NR),  .RGB_RES(RR)) bus1 ();
  hub75_column_driver_if #(.SCAN_RATE(SR), .NUM_ROWS(NR2), .RGB_RES(RR)) bus2 ();

  logic [2:0] rgb0_1, rgb1_1, rgb0_2, rgb1_2;
  logic [4:0] addr_1, addr_2;
  logic       sclk_1, lat_1, oe_n_1, sclk_2, lat_2, oe_n_2;

  hub75_column_driver #(.NUM_COLS(NC), .SCAN_RATE(SR), .NUM_ROWS(NR), .RGB_RES(RR),
                        .CLK_DIV(1), .OE_BASE(8)) u_dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus1),
    .hub75_rgb0(rgb0_1), .hub75_rgb1(rgb1_1), .hub75_addr(addr_1),
    .hub75_clk(sclk_1), .hub75_lat(lat_1), .hub75_oe_n(oe_n_1));

  hub75_column_driver #(.NUM_COLS(NC), .SCAN_RATE(SR), .NUM_ROWS(NR2), .RGB_RES(RR),
                        .CLK_DIV(3), .OE_BASE(8)) u_dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus2),
    .hub75_rgb0(rgb0_2), .hub75_rgb1(rgb1_2), .hub75_addr(addr_2),
    .hub75_clk(sclk_2), .hub75_lat(lat_2), .hub75_oe_n(oe_n_2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Pixel layout {R[8:6],G[5:3],B[2:0]}; plane p shows {R[p],G[p],B[p]}.
  function automatic logic [2:0] exp_bits(input logic [8:0] px, input int p);
    return {px[6+p], px[3+p], px[p]};
  endfunction

  // Scoreboard queues
  logic [5:0] pix_q[$];
  int         lat_q[$];
  int         oe_q[$];
  xfer_t      xfer_q[$];
  logic [5:0] pix2_q[$];
  int         busy2_q[$];
  int         plane2_q[$];

  int oe_len[3]    = '{8, 16, 32};
  int plane2_len[3] = '{394, 402, 418};
  bit mon_en = 1'b0;

  task automatic send1(input cols_t c, input int col, input bit b2b);
    int n;
    xfer_t x;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NC; i++) pix_q.push_back({exp_bits(c[0][i], p), exp_bits(c[1][i], p)});
      lat_q.push_back(col);
      oe_q.push_back(oe_len[p]);
    end
    x.busy = 446;
    x.b2b  = b2b;
    xfer_q.push_back(x);
    bus1.columns    = c;
    bus1.col_num    = 5'(col);
    bus1.data_valid = 1'b1;
    n = 0;
    @(negedge clk_in);
    while (!bus1.hub75_ready && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("accept_wait1", bus1.hub75_ready, 1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic send2(input cols2_t c, input int col);
    int n;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NC; i++) pix2_q.push_back({exp_bits(c[0][i], p), exp_bits(c[1][i], p)});
      plane2_q.push_back(plane2_len[p]);
    end
    busy2_q.push_back(1214);
    bus2.columns    = c;
    bus2.col_num    = 5'(col);
    bus2.data_valid = 1'b1;
    n = 0;
    @(negedge clk_in);
    while (!bus2.hub75_ready && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("accept_wait2", bus2.hub75_ready, 1);
    @(posedge clk_in);
    #1;
    bus2.data_valid = 1'b0;
  endtask

  // Monitor for the CLK_DIV=1 instance
  initial begin
    logic p_clk, p_lat, p_oe, p_rdy;
    logic [4:0] p_addr;
    int lat_run, oe_run, busy_run, hi_run;
    bit busy_on, addr_pend;
    p_clk = 0; p_lat = 0; p_oe = 1; p_rdy = 0; p_addr = 0;
    lat_run = 0; oe_run = 0; busy_run = 0; hi_run = 0; busy_on = 0; addr_pend = 0;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        if (addr_pend) begin
          check("addr_then_lat", lat_1, 1);
          addr_pend = 0;
        end
        if (addr_1 !== p_addr) begin
          check("addr_chg_safe", {p_oe, p_lat, oe_n_1, lat_1}, 4'b1010);
          addr_pend = 1;
        end
        if (sclk_1 !== p_clk) check("clk_toggle_safe", {lat_1, oe_n_1}, 2'b01);
        if (sclk_1 && !p_clk) begin
          if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
          else check("pix_rgb", {rgb0_1, rgb1_1}, pix_q.pop_front());
        end
        if (lat_1) begin
          lat_run++;
          if (!p_lat) begin
            if (lat_q.size() == 0) check("lat_unexpected", 1, 0);
            else check("lat_addr", addr_1, lat_q.pop_front());
          end
        end else if (p_lat) begin
          check("lat_width", lat_run, 1);
          lat_run = 0;
        end
        if (!oe_n_1) oe_run++;
        else if (!p_oe) begin
          if (oe_q.size() == 0) check("oe_unexpected", 1, 0);
          else check("oe_len", oe_run, oe_q.pop_front());
          oe_run = 0;
        end
        if (!bus1.hub75_ready) begin
          if (p_rdy) begin
            if (xfer_q.size() > 0 && xfer_q[0].b2b) check("b2b_gap", hi_run, 1);
            busy_on = 1;
            busy_run = 0;
          end
          busy_run++;
        end else begin
          if (!p_rdy) begin
            hi_run = 0;
            if (busy_on) begin
              if (xfer_q.size() == 0) check("busy_unexpected", 1, 0);
              else check("busy_len", busy_run, xfer_q.pop_front().busy);
              busy_on = 0;
            end
          end
          hi_run++;
        end
      end
      p_clk = sclk_1; p_lat = lat_1; p_oe = oe_n_1; p_rdy = bus1.hub75_ready; p_addr = addr_1;
    end
  end

  // Monitor for the CLK_DIV=3 instance
  initial begin
    logic p_clk, p_oe, p_rdy;
    logic [5:0] hold;
    int hi2, lo2, idx2, cyc2, last_end;
    bit busy_on;
    p_clk = 0; p_oe = 1; p_rdy = 0; hold = '0;
    hi2 = 0; lo2 = 0; idx2 = 0; cyc2 = 0; last_end = 0; busy_on = 0;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        if (!bus2.hub75_ready && p_rdy) begin
          busy_on = 1; cyc2 = 0; last_end = 0; idx2 = 0;
        end
        if (busy_on) cyc2++;
        if (sclk_2 && !p_clk) begin
          if (idx2 % NC != 0) check("div3_low", lo2, 3);
          idx2++;
          hi2 = 0;
          hold = {rgb0_2, rgb1_2};
          if (pix2_q.size() == 0) check("pix2_unexpected", 1, 0);
          else check("pix2_rgb", {rgb0_2, rgb1_2}, pix2_q.pop_front());
        end else if (!sclk_2 && p_clk) begin
          check("div3_high", hi2, 3);
          lo2 = 0;
        end else if (sclk_2) begin
          check("div3_stable", {rgb0_2, rgb1_2}, hold);
        end
        if (sclk_2) hi2++;
        else lo2++;
        if (oe_n_2 && !p_oe && busy_on) begin
          if (plane2_q.size() == 0) check("plane2_unexpected", 1, 0);
          else check("plane2_len", cyc2 - 1 - last_end, plane2_q.pop_front());
          last_end = cyc2 - 1;
        end
        if (bus2.hub75_ready && !p_rdy && busy_on) begin
          if (busy2_q.size() == 0) check("busy2_unexpected", 1, 0);
          else check("busy2_len", cyc2 - 1, busy2_q.pop_front());
          busy_on = 0;
        end
      end
      p_clk = sclk_2; p_oe = oe_n_2; p_rdy = bus2.hub75_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cols_t  c1, c2, c3, junk;
    cols2_t c4;
    int n;
    bus1.data_valid = 0; bus1.col_num = '0; bus1.columns = '0;
    bus2.data_valid = 0; bus2.col_num = '0; bus2.columns = '0;

    for (int i = 0; i < NR; i++) begin
      c1[0][i] = (i % 2 == 0) ? 9'h1FF : 9'h000;
      c1[1][i] = 9'h000;
      c2[0][i] = 9'(i * 37 + 11);
      c2[1][i] = 9'(~(i * 53));
      c3[0][i] = 9'(i * i);
      c3[1][i] = 9'(511 - i * 7);
      junk[0][i] = 9'h155;
      junk[1][i] = 9'h0AA;
    end
    c2[0][0] = 9'b100_010_001;
    for (int i = 0; i < NR2; i++) begin
      c4[0][i] = (i < NC) ? 9'(i * 29 + 3) : 9'h1FF;
      c4[1][i] = (i < NC) ? 9'(i * 71) : 9'h1FF;
    end

    // Reset release, then abort a transfer mid-shift with reset
    repeat (3) @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_ready_pre_edge", bus1.hub75_ready, 0);
    @(negedge clk_in);
    check("rst_ready_post_edge", bus1.hub75_ready, 1);
    bus1.columns = c1; bus1.col_num = 5'd9; bus1.data_valid = 1'b1;
    @(posedge clk_in);
    #1 bus1.data_valid = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    check("pre_rst_busy", bus1.hub75_ready, 0);
    #3 rst_n_in = 1'b0;
    #1;
    check("rst_ready", bus1.hub75_ready, 0);
    check("rst_rgb", {rgb0_1, rgb1_1}, 6'd0);
    check("rst_addr", addr_1, 5'd0);
    check("rst_pins", {sclk_1, lat_1, oe_n_1}, 3'b001);
    @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst2_ready_pre_edge", bus1.hub75_ready, 0);
    @(negedge clk_in);
    check("rst2_ready_post_edge", bus1.hub75_ready, 1);
    check("idle_rgb", {rgb0_1, rgb1_1}, 6'd0);
    mon_en = 1'b1;
    @(posedge clk_in);
    #1;

    // Three transfers; data_valid stays high with the next line while each is in progress
    send1(c1, 5, 1'b0);
    send1(c2, 3, 1'b1);
    send1(c3, 31, 1'b1);
    bus1.columns = junk; bus1.col_num = 5'd17;
    repeat (100) @(posedge clk_in);
    #1 bus1.data_valid = 1'b0;
    n = 0;
    while (xfer_q.size() != 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    repeat (5) @(negedge clk_in);
    check("pix_q_drained", pix_q.size(), 0);
    check("lat_q_drained", lat_q.size(), 0);
    check("oe_q_drained", oe_q.size(), 0);
    check("xfer_q_drained", xfer_q.size(), 0);
    check("final_addr", addr_1, 5'd31);

    // CLK_DIV=3 instance
    @(posedge clk_in);
    #1;
    send2(c4, 7);
    n = 0;
    while (busy2_q.size() != 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    repeat (3) @(negedge clk_in);
    check("pix2_q_drained", pix2_q.size(), 0);
    check("plane2_q_drained", plane2_q.size(), 0);
    check("busy2_q_drained", busy2_q.size(), 0);
    check("final_addr2", addr_2, 5'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
